seg_count_cmp: RTL and testbench

- Parametrised successor to the fixed 16-bit segmented counter/comparator benchmark block: STAGES counter segments of STAGE_W bits each, advanced by an enable, with a segment-wise carry chain.
- Registered compare flag Z against an external vector C, with selectable compare mode.
- Adds what the fixed block lacks: reset, synchronous load, a terminal-count pulse and a saturating hit counter.
- Used as a scan/ATPG test vehicle and as a reusable event timer in the sequential benchmark set.

---
 rtl/seg_count_cmp_pkg.sv | 12 +
 rtl/seg_count_stage.sv | 34 +++
 rtl/seg_count_cmp.sv | 83 ++++++++
 tb/tb_seg_count_cmp.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seg_count_cmp_pkg.sv
// Shared encodings for the segmented counter/comparator.
package seg_count_cmp_pkg;

    // Compare mode applied between the counter value and the compare vector
    typedef enum logic [1:0] {
        MODE_EQ  = 2'b00,
        MODE_GE  = 2'b01,
        MODE_ANY = 2'b10,
        MODE_OFF = 2'b11
    } mode_e;

endpackage

// File: rtl/seg_count_stage.sv
// One counter segment: loadable, increments when the carry-in is set.
module seg_count_stage #(
    parameter int unsigned STAGE_W = 4
) (
    input  logic               ck,
    input  logic               rst,
    input  logic               ld,
    input  logic [STAGE_W-1:0] ld_slice,
    input  logic               carry_in,
    output logic [STAGE_W-1:0] slice,
    output logic               carry_out
);

    logic [STAGE_W-1:0] slice_q;

    // Segment register: load has priority over the incoming carry
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            slice_q <= '0;
        end else if (ld) begin
            slice_q <= ld_slice;
        end else if (carry_in) begin
            slice_q <= slice_q + STAGE_W'(1);
        end
    end

    // Carry ripples onward only when this segment is about to roll over
    always_comb begin
        carry_out = carry_in & (&slice_q);
    end

    assign slice = slice_q;

endmodule

// File: rtl/seg_count_cmp.sv
// Segmented up-counter with registered compare flag, terminal-count pulse
// and a saturating hit counter.
module seg_count_cmp
    import seg_count_cmp_pkg::*;
#(
    parameter int unsigned STAGE_W = 4,
    parameter int unsigned STAGES  = 4,
    parameter int unsigned HIT_W   = 8,
    localparam int unsigned CNT_W  = STAGE_W * STAGES
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             EN,
    input  logic             LD,
    input  logic [CNT_W-1:0] LD_VAL,
    input  logic [CNT_W-1:0] C,
    input  logic [1:0]       MODE,
    input  logic             CLR_HITS,
    output logic [CNT_W-1:0] Q,
    output logic             Z,
    output logic             TC,
    output logic [HIT_W-1:0] HITS
);

    logic [STAGES:0]    carry;
    logic [CNT_W-1:0]   cnt;
    logic               z_next;
    logic               z_q;
    logic               tc_q;
    logic [HIT_W-1:0]   hits_q;

    assign carry[0] = EN;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        seg_count_stage #(
            .STAGE_W(STAGE_W)
        ) u_stage (
            .ck       (CK),
            .rst      (RST),
            .ld       (LD),
            .ld_slice (LD_VAL[k*STAGE_W +: STAGE_W]),
            .carry_in (carry[k]),
            .slice    (cnt[k*STAGE_W +: STAGE_W]),
            .carry_out(carry[k+1])
        );
    end

    // Compare the current count against C under the selected mode
    always_comb begin
        z_next = 1'b0;
        unique case (mode_e'(MODE))
            MODE_EQ:  z_next = (cnt == C);
            MODE_GE:  z_next = (cnt >= C);
            MODE_ANY: z_next = |(cnt & C);
            MODE_OFF: z_next = 1'b0;
            default:  z_next = 1'b0;
        endcase
    end

    // Compare flag, wrap pulse and saturating hit counter
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            z_q    <= 1'b0;
            tc_q   <= 1'b0;
            hits_q <= '0;
        end else begin
            z_q  <= z_next;
            // Carry out of the top segment means all-ones with EN set
            tc_q <= ~LD & carry[STAGES];
            if (CLR_HITS) begin
                hits_q <= '0;
            end else if (z_q && !(&hits_q)) begin
                hits_q <= hits_q + HIT_W'(1);
            end
        end
    end

    assign Q    = cnt;
    assign Z    = z_q;
    assign TC   = tc_q;
    assign HITS = hits_q;

endmodule

// File: tb/tb_seg_count_cmp.sv
// Self-checking bench for seg_count_cmp with default parameters.
module tb_seg_count_cmp;

    logic        CK = 1'b0;
    logic        RST = 1'b0;
    logic        EN = 1'b0;
    logic        LD = 1'b0;
    logic [15:0] LD_VAL = '0;
    logic [15:0] C = '0;
    logic [1:0]  MODE = 2'b11;
    logic        CLR_HITS = 1'b0;
    logic [15:0] Q;
    logic        Z;
    logic        TC;
    logic [7:0]  HITS;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    int unsigned m_q = 0;
    bit          m_z = 0;
    bit          m_tc = 0;
    int unsigned m_hits = 0;

    seg_count_cmp dut (
        .CK      (CK),
        .RST     (RST),
        .EN      (EN),
        .LD      (LD),
        .LD_VAL  (LD_VAL),
        .C       (C),
        .MODE    (MODE),
        .CLR_HITS(CLR_HITS),
        .Q       (Q),
        .Z       (Z),
        .TC      (TC),
        .HITS    (HITS)
    );

    always #5 CK = ~CK;

    function automatic bit model_cmp(int unsigned q, int unsigned c, logic [1:0] mode);
        case (mode)
            2'b00:   return q == c;
            2'b01:   return q >= c;
            2'b10:   return (q & c) != 0;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge CK or posedge RST) begin
        if (RST) begin
            m_q    <= 0;
            m_z    <= 0;
            m_tc   <= 0;
            m_hits <= 0;
        end else begin
            if (LD) m_q <= LD_VAL;
            else if (EN) m_q <= (m_q + 1) % 65536;
            m_tc <= !LD && EN && (m_q == 65535);
            m_z  <= model_cmp(m_q, C, MODE);
            if (CLR_HITS) m_hits <= 0;
            else if (m_z && m_hits < 255) m_hits <= m_hits + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge CK) begin
        if (chk_en) begin
            check("model_q", int'(Q), int'(m_q));
            check("model_z", int'(Z), int'(m_z));
            check("model_tc", int'(TC), int'(m_tc));
            check("model_hits", int'(HITS), int'(m_hits));
        end
    end

    task automatic tick();
        @(negedge CK);
    endtask

    task automatic load(input logic [15:0] v);
        LD = 1'b1; LD_VAL = v; EN = 1'b0;
        tick();
        LD = 1'b0;
    endtask

    logic [7:0] z_exp;

    initial begin
        #3 RST = 1'b1;
        #1;
        check("reset_q", int'(Q), 0);
        check("reset_z", int'(Z), 0);
        check("reset_tc", int'(TC), 0);
        check("reset_hits", int'(HITS), 0);
        tick();
        RST = 1'b0;
        tick();
        chk_en = 1'b1;

        // Carry ripple
        load(16'h00FF);
        EN = 1'b1; tick(); EN = 1'b0;
        check("ripple_0100", int'(Q), 16'h0100);
        load(16'h0FFF);
        EN = 1'b1; tick(); EN = 1'b0;
        check("ripple_1000", int'(Q), 16'h1000);

        // Wrap and terminal count
        load(16'hFFFE);
        EN = 1'b1;
        tick();
        check("wrap_q_ffff", int'(Q), 16'hFFFF);
        check("wrap_tc0", int'(TC), 0);
        tick();
        check("wrap_q_0000", int'(Q), 16'h0000);
        check("wrap_tc1", int'(TC), 1);
        tick();
        check("wrap_q_0001", int'(Q), 16'h0001);
        check("wrap_tc_after", int'(TC), 0);
        EN = 1'b0;

        // Load beats enable
        load(16'h0005);
        LD = 1'b1; EN = 1'b1; LD_VAL = 16'h0010;
        tick();
        LD = 1'b0; EN = 1'b0;
        check("prio_q", int'(Q), 16'h0010);
        check("prio_tc", int'(TC), 0);

        // Compare modes with C=3; bit j of z_exp is Z after Q=j
        C = 16'h0003;
        for (int m = 0; m < 4; m++) begin
            MODE = 2'(m);
            case (m)
                0:       z_exp = 8'b0000_1000;
                1:       z_exp = 8'b1111_1000;
                2:       z_exp = 8'b1110_1110;
                default: z_exp = 8'b0000_0000;
            endcase
            load(16'h0000);
            EN = 1'b1;
            for (int i = 1; i <= 8; i++) begin
                tick();
                check($sformatf("mode%0d_z_after_q%0d", m, i - 1), int'(Z), int'(z_exp[i-1]));
            end
            EN = 1'b0;
        end

        // Hit counter saturation and clear
        MODE = 2'b01; C = 16'h0000;
        CLR_HITS = 1'b1; tick(); CLR_HITS = 1'b0;
        EN = 1'b1;
        repeat (300) tick();
        check("hits_sat", int'(HITS), 8'hFF);
        repeat (5) tick();
        check("hits_hold", int'(HITS), 8'hFF);
        check("hits_z_high", int'(Z), 1);
        CLR_HITS = 1'b1; tick(); CLR_HITS = 1'b0;
        check("hits_clr", int'(HITS), 0);
        tick();
        check("hits_after_clr", int'(HITS), 1);
        EN = 1'b0;

        // Asynchronous reset mid-count
        load(16'h1234);
        EN = 1'b1;
        tick();
        #2 RST = 1'b1;
        #1;
        check("midrst_q", int'(Q), 0);
        check("midrst_z", int'(Z), 0);
        check("midrst_tc", int'(TC), 0);
        check("midrst_hits", int'(HITS), 0);
        tick();
        RST = 1'b0;
        tick();
        check("resume_q1", int'(Q), 1);
        tick();
        check("resume_q2", int'(Q), 2);
        EN = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
